// File: rtl/ctrl_pkg_r32i.sv
// Shared control definitions for the RV32I multi-cycle core: sequencer state
// encoding and the memory address mux select values used by the datapath.
package ctrl_pkg_r32i;

    typedef enum logic [2:0] {
        ST_RESET   = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_EXECUTE = 3'd3,
        ST_MEM     = 3'd4,
        ST_WB      = 3'd5,
        ST_HALT    = 3'd6,
        ST_FAULT   = 3'd7
    } seq_state_t;

    localparam logic MEM_SEL_PC  = 1'b0;
    localparam logic MEM_SEL_ALU = 1'b1;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts memory wait cycles for one access; expired flags that the allowed
// number of waits has been used up. MEM_TIMEOUT = 0 never expires.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count,
    output logic expired
);

    localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT);

    logic [CW-1:0] cnt_q, cnt_d;

    // Saturates at the limit so a held expiry cannot wrap back to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (count && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (MEM_TIMEOUT > 0) && (cnt_q == LIMIT);

endmodule

// File: rtl/sequencer_r32i.sv
// Multi-cycle RV32I control sequencer: fetch/decode/execute/mem/writeback with
// halt/run control, memory timeout fault and a retired-instruction counter.
module sequencer_r32i
    import ctrl_pkg_r32i::*;
#(
    parameter int dataW       = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             nReset,
    input  logic             RegWriteControl,
    input  logic             LinkAddrWrite,
    input  logic             TestBranch,
    input  logic             AlwaysBranch,
    input  logic             AbsoluteBranch,
    input  logic             RAMRead,
    input  logic             RAMWrite,
    input  logic             BranchTaken,
    input  logic             MemReady,
    input  logic             Halt,
    input  logic             Run,
    output logic             IRLoad,
    output logic             MemReq,
    output logic             MemWE,
    output logic             MemAddrSel,
    output logic             RegWE,
    output logic             LinkSel,
    output logic             PCUpdate,
    output logic             PCBranch,
    output logic             PCAbs,
    output logic             Halted,
    output logic             Fault,
    output logic [dataW-1:0] RetiredCount
);

    seq_state_t       state_q, state_d;
    logic             br_taken_q, br_taken_d;
    logic [dataW-1:0] retired_q, retired_d;
    logic             wait_expired;

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_wait (
        .clk    (clk),
        .rst_n  (nReset),
        .clear  ((state_q != ST_FETCH) && (state_q != ST_MEM)),
        .count  (!MemReady),
        .expired(wait_expired)
    );

    always_comb begin
        state_d    = state_q;
        br_taken_d = br_taken_q;
        retired_d  = retired_q;
        IRLoad     = 1'b0;
        MemReq     = 1'b0;
        MemWE      = 1'b0;
        MemAddrSel = MEM_SEL_PC;
        RegWE      = 1'b0;
        LinkSel    = 1'b0;
        PCUpdate   = 1'b0;
        PCBranch   = 1'b0;
        PCAbs      = 1'b0;
        Halted     = 1'b0;
        Fault      = 1'b0;
        case (state_q)
            ST_RESET: state_d = ST_FETCH;
            ST_FETCH: begin
                MemReq = 1'b1;
                IRLoad = MemReady;
                if (MemReady)          state_d = ST_DECODE;
                else if (wait_expired) state_d = ST_FAULT;
            end
            ST_DECODE: state_d = ST_EXECUTE;
            ST_EXECUTE: begin
                br_taken_d = AlwaysBranch | (TestBranch & BranchTaken);
                state_d    = (RAMWrite | RAMRead) ? ST_MEM : ST_WB;
            end
            ST_MEM: begin
                // A store is decoded with both RAM flags set; write wins.
                MemReq     = 1'b1;
                MemAddrSel = MEM_SEL_ALU;
                MemWE      = RAMWrite;
                if (MemReady)          state_d = ST_WB;
                else if (wait_expired) state_d = ST_FAULT;
            end
            ST_WB: begin
                RegWE     = RegWriteControl;
                LinkSel   = LinkAddrWrite;
                PCUpdate  = 1'b1;
                PCBranch  = br_taken_q;
                PCAbs     = AbsoluteBranch & br_taken_q;
                retired_d = retired_q + dataW'(1);
                state_d   = Halt ? ST_HALT : ST_FETCH;
            end
            ST_HALT: begin
                Halted = 1'b1;
                if (Run) state_d = ST_FETCH;
            end
            ST_FAULT: Fault = 1'b1;
            default:  state_d = ST_RESET;
        endcase
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q    <= ST_RESET;
            br_taken_q <= 1'b0;
            retired_q  <= '0;
        end else begin
            state_q    <= state_d;
            br_taken_q <= br_taken_d;
            retired_q  <= retired_d;
        end
    end

    assign RetiredCount = retired_q;

endmodule

// File: tb/tb_sequencer_r32i.sv
// Bench for sequencer_r32i: instruction-level schedules (table + random)
// expanded into expected per-cycle outputs, plus fault and reset sequences.
module tb_sequencer_r32i;

    localparam int TO = 4;

    typedef struct {
        string      nm;
        logic [6:0] fl;      // {RegWr, Link, Test, Always, Abs, RamRd, RamWr}
        logic       bt;
        int         fw;      // fetch wait cycles (> TO means never ready)
        int         mw;      // mem wait cycles
        bit         hlt;
        int         runw;
        logic [3:0] exp_wb;  // {RegWE, LinkSel, PCBranch, PCAbs}
        logic       exp_we;
    } vec_t;

    logic        clk = 1'b0;
    logic        nReset = 1'b0;
    logic [6:0]  fl_i = '0;
    logic        BranchTaken = 1'b0, MemReady = 1'b0, Halt = 1'b0, Run = 1'b0;
    logic        IRLoad, MemReq, MemWE, MemAddrSel, RegWE, LinkSel;
    logic        PCUpdate, PCBranch, PCAbs, Halted, Fault;
    logic [31:0] RetiredCount;
    logic        q_irl, q_req, q_we, q_sel, q_rwe, q_lnk, q_pcu, q_pcb, q_pca, q_hlt, q_flt;
    logic [3:0]  rc4;
    logic [10:0] outs, outs4;
    logic [31:0] ret_model = '0;
    int          n_chk = 0, n_fail = 0;
    vec_t        tbl[9];
    vec_t        v;

    always #5 clk = ~clk;

    sequencer_r32i #(.dataW(32), .MEM_TIMEOUT(TO)) dut (
        .clk(clk), .nReset(nReset),
        .RegWriteControl(fl_i[6]), .LinkAddrWrite(fl_i[5]), .TestBranch(fl_i[4]),
        .AlwaysBranch(fl_i[3]), .AbsoluteBranch(fl_i[2]), .RAMRead(fl_i[1]), .RAMWrite(fl_i[0]),
        .BranchTaken(BranchTaken), .MemReady(MemReady), .Halt(Halt), .Run(Run),
        .IRLoad(IRLoad), .MemReq(MemReq), .MemWE(MemWE), .MemAddrSel(MemAddrSel),
        .RegWE(RegWE), .LinkSel(LinkSel), .PCUpdate(PCUpdate), .PCBranch(PCBranch),
        .PCAbs(PCAbs), .Halted(Halted), .Fault(Fault), .RetiredCount(RetiredCount)
    );

    // Narrow counter instance exercises the wrap from all-ones to zero.
    sequencer_r32i #(.dataW(4), .MEM_TIMEOUT(TO)) dut4 (
        .clk(clk), .nReset(nReset),
        .RegWriteControl(fl_i[6]), .LinkAddrWrite(fl_i[5]), .TestBranch(fl_i[4]),
        .AlwaysBranch(fl_i[3]), .AbsoluteBranch(fl_i[2]), .RAMRead(fl_i[1]), .RAMWrite(fl_i[0]),
        .BranchTaken(BranchTaken), .MemReady(MemReady), .Halt(Halt), .Run(Run),
        .IRLoad(q_irl), .MemReq(q_req), .MemWE(q_we), .MemAddrSel(q_sel),
        .RegWE(q_rwe), .LinkSel(q_lnk), .PCUpdate(q_pcu), .PCBranch(q_pcb),
        .PCAbs(q_pca), .Halted(q_hlt), .Fault(q_flt), .RetiredCount(rc4)
    );

    assign outs  = {IRLoad, MemReq, MemWE, MemAddrSel, RegWE, LinkSel, PCUpdate,
                    PCBranch, PCAbs, Halted, Fault};
    assign outs4 = {q_irl, q_req, q_we, q_sel, q_rwe, q_lnk, q_pcu, q_pcb, q_pca, q_hlt, q_flt};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [6:0] rf();
        return 7'($urandom_range(0, 127));
    endfunction

    task automatic check_all(input string nm, input logic [10:0] exp);
        chk({nm, ".outs"}, {21'b0, outs}, {21'b0, exp});
        chk({nm, ".outs4"}, {21'b0, outs4}, {21'b0, exp});
        chk({nm, ".retired"}, RetiredCount, ret_model);
        chk({nm, ".retired4"}, {28'b0, rc4}, {28'b0, ret_model[3:0]});
    endtask

    task automatic cyc(input string nm, input logic [10:0] exp, input logic rdy,
                       input logic [6:0] fl, input logic bt, input logic hl, input logic rn);
        @(negedge clk);
        MemReady = rdy; fl_i = fl; BranchTaken = bt; Halt = hl; Run = rn;
        #1;
        check_all(nm, exp);
    endtask

    task automatic do_reset(input string nm);
        @(negedge clk);
        MemReady = 1'b0;
        #2 nReset = 1'b0;
        ret_model = '0;
        #1 check_all({nm, ".async"}, 11'b0);
        @(negedge clk);
        nReset = 1'b1;
        #1 check_all({nm, ".reset_state"}, 11'b0);
    endtask

    // Expands one instruction into its expected cycle-by-cycle behaviour.
    task automatic run_instr(input vec_t iv, input int rst_at);
        bit done;
        for (int i = 0; ; i++) begin
            if (i > TO) begin
                for (int k = 0; k < 3; k++) cyc({iv.nm, ".fault"}, 11'b1, rb(), rf(), rb(), rb(), rb());
                return;
            end
            done = (i == iv.fw);
            cyc({iv.nm, ".fetch"}, {done, 1'b1, 9'b0}, done, rf(), rb(), rb(), rb());
            if (done) break;
        end
        cyc({iv.nm, ".decode"}, 11'b0, rb(), rf(), rb(), rb(), rb());
        cyc({iv.nm, ".execute"}, 11'b0, rb(), iv.fl, iv.bt, 1'b1, rb());
        if (iv.fl[1] | iv.fl[0]) begin
            for (int i = 0; ; i++) begin
                if (i == rst_at) begin
                    do_reset({iv.nm, ".midmem"});
                    return;
                end
                if (i > TO) begin
                    for (int k = 0; k < 3; k++) cyc({iv.nm, ".fault"}, 11'b1, rb(), rf(), rb(), rb(), rb());
                    return;
                end
                done = (i == iv.mw);
                cyc({iv.nm, ".mem"}, {1'b0, 1'b1, iv.exp_we, 1'b1, 7'b0}, done, iv.fl, rb(), rb(), rb());
                if (done) break;
            end
        end
        cyc({iv.nm, ".wb"}, {4'b0, iv.exp_wb[3:2], 1'b1, iv.exp_wb[1:0], 2'b0},
            rb(), iv.fl, rb(), iv.hlt, rb());
        ret_model = ret_model + 32'd1;
        if (iv.hlt) begin
            for (int i = 0; i <= iv.runw; i++)
                cyc({iv.nm, ".halt"}, 11'b10, rb(), rf(), rb(), 1'b1, 1'(i == iv.runw));
        end
    endtask

    function automatic vec_t rand_vec();
        vec_t r;
        logic brt;
        r.nm   = "rand";
        r.fl   = rf();
        r.bt   = rb();
        r.fw   = int'($urandom_range(0, TO));
        r.mw   = int'($urandom_range(0, TO));
        r.hlt  = ($urandom_range(0, 3) == 0);
        r.runw = int'($urandom_range(0, 3));
        brt    = r.fl[3] | (r.fl[4] & r.bt);
        r.exp_wb = {r.fl[6], r.fl[5], brt, r.fl[2] & brt};
        r.exp_we = r.fl[0];
        return r;
    endfunction

    initial begin
        tbl[0] = '{"addi",      7'b1000000, 1'b0, 0, 0, 1'b0, 0, 4'b1000, 1'b0};
        tbl[1] = '{"store",     7'b0000011, 1'b0, 0, 3, 1'b0, 0, 4'b0000, 1'b1};
        tbl[2] = '{"beq_t",     7'b0010000, 1'b1, 0, 0, 1'b0, 0, 4'b0010, 1'b0};
        tbl[3] = '{"beq_nt",    7'b0010000, 1'b0, 0, 0, 1'b0, 0, 4'b0000, 1'b0};
        tbl[4] = '{"jalr",      7'b1101100, 1'b0, 1, 0, 1'b0, 0, 4'b1111, 1'b0};
        tbl[5] = '{"jal",       7'b1101000, 1'b0, 0, 0, 1'b0, 0, 4'b1110, 1'b0};
        tbl[6] = '{"load_w4",   7'b1000010, 1'b0, 2, TO, 1'b0, 0, 4'b1000, 1'b0};
        tbl[7] = '{"addi_halt", 7'b1000000, 1'b1, TO, 0, 1'b1, 3, 4'b1000, 1'b0};
        tbl[8] = '{"br_abs_nt", 7'b0010100, 1'b0, 0, 0, 1'b1, 0, 4'b0000, 1'b0};

        do_reset("por");
        foreach (tbl[i]) run_instr(tbl[i], -1);
        repeat (40) run_instr(rand_vec(), -1);

        v = tbl[0]; v.nm = "fetch_to"; v.fw = 99;
        run_instr(v, -1);
        do_reset("clr_fault1");
        v = tbl[6]; v.nm = "mem_to"; v.mw = 99;
        run_instr(v, -1);
        do_reset("clr_fault2");
        v = tbl[6]; v.nm = "load_rst"; v.mw = 99;
        run_instr(v, 2);
        run_instr(tbl[0], -1);
        cyc("post", {1'b0, 1'b1, 9'b0}, 1'b0, rf(), rb(), rb(), rb());

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/sequencer_r32i.md
# sequencer_r32i

Multi-cycle control FSM for the RV32I core: sequences instruction fetch, decode, execute, memory access and writeback around the instruction decoder. Consumes the decoder's control flags and a memory ready handshake, and emits the per-cycle enables (IR load, PC update, register write, RAM request). Also provides halt/run control, a memory timeout fault and a retired-instruction counter.

## Interface
- `dataW`, 32: datapath width; also the width of `RetiredCount`.
- `MEM_TIMEOUT`, 255: maximum wait cycles for `MemReady` per access; 0 disables the timeout.
- `clk` input 1: single core clock, rising edge.
- `nReset` input 1: asynchronous, active-low reset.
- `RegWriteControl`, `LinkAddrWrite`, `TestBranch`, `AlwaysBranch`, `AbsoluteBranch`, `RAMRead`, `RAMWrite` input 1 each: decoder flags, decoded from the latched IR.
- `BranchTaken` input 1: conditional-branch result from the condition generator.
- `MemReady` input 1: memory completes the current request this cycle.
- `Halt` input 1: stop at the next instruction boundary.
- `Run` input 1: resume from HALT.
- `IRLoad` output 1: latch the fetched word into the IR.
- `MemReq` output 1: memory request valid.
- `MemWE` output 1: the request is a store.
- `MemAddrSel` output 1: 0 = PC, 1 = ALU result.
- `RegWE` output 1: register file write enable.
- `LinkSel` output 1: write data = PC+4 instead of ALU/RAM.
- `PCUpdate` output 1: PC register enable.
- `PCBranch` output 1: PC takes the branch target instead of PC+4.
- `PCAbs` output 1: branch target is absolute (ALU result), not PC-relative.
- `Halted` output 1: FSM is in HALT.
- `Fault` output 1: FSM is in FAULT (sticky).
- `RetiredCount` output dataW: count of completed instructions.

## Operation
States: RESET, FETCH, DECODE, EXECUTE, MEM, WB, HALT, FAULT. All outputs except `RetiredCount` are decoded combinationally from the state and the flags.
- RESET: all outputs 0. Unconditionally goes to FETCH on the first edge after `nReset` rises.
- FETCH: `MemReq`=1, `MemAddrSel`=0, `MemWE`=0.
  - `IRLoad` = `MemReady`.
  - On `MemReady` go to DECODE; otherwise stay.
- DECODE: one cycle; all outputs 0. The decoder flags settle from the IR.
- EXECUTE: one cycle. Register `brTaken = AlwaysBranch | (TestBranch & BranchTaken)`.
  - If `RAMWrite | RAMRead`, go to MEM; else go to WB.
- MEM: `MemReq`=1, `MemAddrSel`=1, `MemWE`=`RAMWrite`.
  - `RAMWrite` takes precedence: the decoder raises both `RAMRead` and `RAMWrite` for a store, and that case is a store.
  - On `MemReady` go to WB.
- WB: one cycle; retires the instruction.
  - `RegWE`=`RegWriteControl`, `LinkSel`=`LinkAddrWrite`, `PCUpdate`=1.
  - `PCBranch`=`brTaken`, `PCAbs`=`AbsoluteBranch & brTaken`.
  - `RetiredCount` increments by 1 and wraps from 2^dataW-1 to 0.
  - Next state is HALT if `Halt`, else FETCH.
- HALT: `Halted`=1; all other outputs 0. `Run` goes to FETCH; `Run` has priority over a simultaneously held `Halt`.
- Timeout: a wait counter clears on entry to FETCH or MEM and counts each cycle without `MemReady`.
  - When the counter reaches `MEM_TIMEOUT` with `MemReady` still low, go to FAULT.
  - `MemReady` arriving on the same cycle the limit is reached completes normally.
- FAULT: `Fault`=1; all other outputs 0. Only reset exits this state.
- `Halt` and `Run` are ignored outside WB and HALT respectively. An instruction is never abandoned part-way.

## Timing
- Zero-wait memory: 4 cycles per non-memory instruction (F, D, E, WB) and 5 per load/store.
- Each cycle `MemReady` is low adds one cycle in FETCH or MEM.
- `RetiredCount` updates on the WB edge and is visible on the following cycle.
- Asserting `nReset` mid-access drops `MemReq` immediately and zeroes `RetiredCount`, `brTaken` and the wait counter.
- `MemReady` is ignored in every state other than FETCH and MEM.

## Structure
- Shared package `ctrl_pkg_r32i` holds:
  - the state enum `seq_state_t` (explicit 3-bit encoding);
  - `MEM_SEL_PC` and `MEM_SEL_ALU` constants, shared with the datapath address mux.
- Sub-module `mem_wait_timer`, parameterised by `MEM_TIMEOUT`, with inputs `clear`, `count` and output `expired`.

## Test plan
- ADDI with `MemReady` held at 1 -> state sequence F, D, E, WB, F; one `IRLoad`; `RegWE`=1 in WB only; `RetiredCount` 0 -> 1.
- Store (`RAMRead`=`RAMWrite`=1) with `MemReady` delayed 3 cycles in MEM -> `MemReq`=`MemWE`=`MemAddrSel`=1 for 4 cycles; `RegWE`=0; 8 cycles total.
- BEQ with `BranchTaken`=1, then `BranchTaken`=0 -> `PCBranch`=1 then 0 in WB. JALR -> `PCBranch`=`PCAbs`=`LinkSel`=`RegWE`=1.
- `Halt` pulsed during EXECUTE -> ignored. `Halt` held through WB -> `Halted`=1; `Run` pulse -> FETCH the next cycle.
- `MEM_TIMEOUT`=4 with `MemReady` stuck low in FETCH -> `Fault`=1 after 4 wait cycles; `Fault` stays high until `nReset` is pulsed.
- Preload `RetiredCount`=32'hFFFF_FFFF, retire one instruction -> 0. Assert `nReset` mid-MEM -> all outputs 0 asynchronously.
